// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants for the fetch/decode boundary: NOP encoding,
// register-address field positions and the opcodes that cause a redirect.
package riscv_pkg;

    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam int          RS1_LSB    = 15;
    localparam int          RS2_LSB    = 20;
    localparam int          REG_ADDR_W = 5;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // True for control-transfer instructions that can trigger a queue flush.
    function automatic logic is_redirect(input logic [31:0] inst);
        return (inst[6:0] == OPC_JAL) || (inst[6:0] == OPC_JALR) ||
               (inst[6:0] == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/fd_queue_mem.sv
// Storage array for the fetch/decode queue: one synchronous write port and
// one combinational read port. Contents are not reset.
module fd_queue_mem #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry valid/ready queue between fetch and decode, presenting a NOP
// bubble when empty. Optional counters enabled by FD_QUEUE_STATS_EN.
module fetch_decode_queue
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_valid,
    output logic                  f_ready,
    input  logic [XLEN-1:0]       f_pc,
    input  logic [ILEN-1:0]       f_inst,
    input  logic                  flush,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [XLEN-1:0]       d_pc,
    output logic [ILEN-1:0]       d_inst,
    output logic [REG_ADDR_W-1:0] d_rs1,
    output logic [REG_ADDR_W-1:0] d_rs2
`ifdef FD_QUEUE_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           empty_cycles,
    output logic [31:0]           flush_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 w_push;
    logic                 w_pop;
    logic [XLEN+ILEN-1:0] w_rdata;

    // Ready depends only on the registered count, so a pop cannot free a slot
    // for a push in the same cycle.
    assign f_ready = (r_count != CW'(DEPTH));
    assign d_valid = (r_count != '0);
    assign w_push  = f_valid && f_ready && !flush;
    assign w_pop   = d_valid && d_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    fd_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({f_pc, f_inst}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign d_pc   = d_valid ? w_rdata[XLEN+ILEN-1:ILEN] : '0;
    assign d_inst = d_valid ? w_rdata[ILEN-1:0] : ILEN'(INST_NOP);
    assign d_rs1  = d_inst[RS1_LSB +: REG_ADDR_W];
    assign d_rs2  = d_inst[RS2_LSB +: REG_ADDR_W];

`ifdef FD_QUEUE_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_empty_cycles;
    logic [31:0] r_flush_count;

    // All counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_empty_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (d_valid && !d_ready && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (!d_valid && (r_empty_cycles != '1))
                r_empty_cycles <= r_empty_cycles + 32'd1;
            if (flush && (r_flush_count != '1))
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign empty_cycles = r_empty_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue with a queue scoreboard of expected
// head entries; outputs are sampled 1 time unit after each rising edge.
module tb_fetch_decode_queue;

    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            f_valid;
    logic            f_ready;
    logic [XLEN-1:0] f_pc;
    logic [ILEN-1:0] f_inst;
    logic            flush;
    logic            d_valid;
    logic            d_ready;
    logic [XLEN-1:0] d_pc;
    logic [ILEN-1:0] d_inst;
    logic [4:0]      d_rs1;
    logic [4:0]      d_rs2;

    ent_t sb[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    fetch_decode_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .f_pc    (f_pc),
        .f_inst  (f_inst),
        .flush   (flush),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_pc    (d_pc),
        .d_inst  (d_inst),
        .d_rs1   (d_rs1),
        .d_rs2   (d_rs2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare every output against the scoreboard head (or the empty bubble).
    task automatic check_all(input string tag);
        ent_t e;
        logic [31:0] inst_exp;
        logic [31:0] pc_exp;
        if (sb.size() != 0) begin
            e = sb[0];
            inst_exp = e.inst;
            pc_exp   = e.pc;
        end else begin
            inst_exp = NOP;
            pc_exp   = '0;
        end
        chk({tag, ".d_valid"}, 64'(d_valid), 64'(sb.size() != 0));
        chk({tag, ".f_ready"}, 64'(f_ready), 64'(sb.size() != DEPTH));
        chk({tag, ".d_pc"},    64'(d_pc),    64'(pc_exp));
        chk({tag, ".d_inst"},  64'(d_inst),  64'(inst_exp));
        chk({tag, ".d_rs1"},   64'(d_rs1),   64'(inst_exp[19:15]));
        chk({tag, ".d_rs2"},   64'(d_rs2),   64'(inst_exp[24:20]));
    endtask

    // Drive one cycle of stimulus, update the scoreboard for the edge, check.
    task automatic cycle(input string tag, input logic fv, input logic [31:0] pc,
                         input logic [31:0] inst, input logic dr, input logic fl);
        int   pre;
        logic do_push;
        logic do_pop;
        ent_t e;
        f_valid = fv;
        f_pc    = pc;
        f_inst  = inst;
        d_ready = dr;
        flush   = fl;
        pre     = sb.size();
        do_push = fv && (pre != DEPTH) && !fl;
        do_pop  = dr && (pre != 0) && !fl;
        @(posedge clk);
        #1;
        if (fl) sb.delete();
        else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                e.pc   = pc;
                e.inst = inst;
                sb.push_back(e);
            end
        end
        check_all(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        f_valid = 1'b0;
        f_pc    = '0;
        f_inst  = '0;
        flush   = 1'b0;
        d_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.d_valid", 64'(d_valid), 64'(0));
        chk("rst.d_inst",  64'(d_inst),  64'(NOP));
        chk("rst.d_pc",    64'(d_pc),    64'(0));
        chk("rst.f_ready", 64'(f_ready), 64'(1));
        rst_n = 1'b1;
        cycle("idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // single push then back-pressure for 3 cycles
        cycle("push1", 1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0);
        chk("push1.pc_const",  64'(d_pc),  64'(32'h100));
        chk("push1.rs2_const", 64'(d_rs2), 64'(5));
        chk("push1.rs1_const", 64'(d_rs1), 64'(0));
        for (int i = 0; i < 3; i++) cycle("hold", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle("pop1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle("pop_empty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // fill to full, blocked third push, ordered drain
        cycle("fill0", 1'b1, 32'h100, 32'h0010_8113, 1'b0, 1'b0);
        cycle("fill1", 1'b1, 32'h104, 32'h0031_01b3, 1'b0, 1'b0);
        chk("full.f_ready_const", 64'(f_ready), 64'(0));
        cycle("blocked", 1'b1, 32'h108, 32'h0041_8233, 1'b0, 1'b0);
        cycle("drain0", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain0.pc_const", 64'(d_pc), 64'(32'h104));
        chk("drain0.f_ready_const", 64'(f_ready), 64'(1));
        cycle("drain1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // flush on a full queue with a same-cycle push and pop
        cycle("ffill0", 1'b1, 32'h110, 32'h0052_82b3, 1'b0, 1'b0);
        cycle("ffill1", 1'b1, 32'h114, 32'h0063_0333, 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'h300, 32'h0073_83b3, 1'b1, 1'b1);
        chk("flush.d_inst_const", 64'(d_inst), 64'(NOP));
        cycle("post_flush", 1'b1, 32'h200, 32'h0084_0433, 1'b0, 1'b0);
        chk("post_flush.pc_const", 64'(d_pc), 64'(32'h200));
        cycle("post_flush_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // streaming: pointers wrap several times
        for (int i = 0; i < 10; i++)
            cycle("stream", 1'b1, 32'(i * 4), 32'h0000_0033 | 32'(i << 15) | 32'((i + 1) << 20),
                  1'b1, 1'b0);
        chk("stream.last_pc", 64'(d_pc), 64'(32'h24));
        cycle("stream_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // asynchronous reset mid-operation
        cycle("pre_rst0", 1'b1, 32'h400, 32'h0094_84b3, 1'b0, 1'b0);
        cycle("pre_rst1", 1'b1, 32'h404, 32'h00a5_0533, 1'b0, 1'b0);
        f_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        check_all("async_rst");
        rst_n = 1'b1;
        cycle("after_rst", 1'b1, 32'h500, 32'h00b5_85b3, 1'b0, 1'b0);
        cycle("after_rst_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
